node_eval: RTL

NODE_EVAL -- requirements
Module: node_eval

---
 rtl/node_eval.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/node_eval.sv
// node_eval: evaluates one oblique decision-tree node per pass over a held
// sample. Each node is a dot product of the sample features with streamed
// coefficients, plus a bias. The sign of that sum selects the child.
// The sample stays latched across nodes until path_done ends the walk.
module node_eval #(
  parameter int FEATURES          = 3,
  parameter int FEATURE_BIT_DEPTH = 8,
  parameter int COEFF_BIT_DEPTH   = 4,
  parameter int BIAS_BIT_DEPTH    = 10,
  localparam int ACC_W = FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH + $clog2(FEATURES) + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] sample,
  input  logic                                  sample_valid,
  output logic                                  sample_ready,
  input  logic [COEFF_BIT_DEPTH-1:0]            coeff,
  input  logic                                  is_one,
  input  logic [BIAS_BIT_DEPTH-1:0]             bias,
  input  logic                                  term_valid,
  input  logic                                  path_done,
  output logic                                  child_direction,
  output logic                                  dir_valid,
  output logic [ACC_W-1:0]                      result,
  output logic                                  protocol_error
);

  localparam int FW    = FEATURE_BIT_DEPTH;
  localparam int CW    = COEFF_BIT_DEPTH;
  localparam int BW    = BIAS_BIT_DEPTH;
  localparam int PW    = FW + CW;
  localparam int SW    = FEATURES * FW;
  localparam int CNT_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(FEATURES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

  // Reset: asserts immediately, releases two edges later so the first
  // active edge after release always starts from IDLE.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset release synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t                   state_q, state_d;
  logic [SW-1:0]            sample_q, sample_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  bias_q, bias_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ready_q, ready_d;
  logic                     dir_q, dir_d;
  logic                     dvalid_q, dvalid_d;
  logic [ACC_W-1:0]         result_q, result_d;
  logic                     perr_q, perr_d;

  // Unpack the held sample into one signed word per feature.
  logic signed [FW-1:0] feat [FEATURES];

  genvar gi;
  generate
    for (gi = 0; gi < FEATURES; gi++) begin : g_feat
      assign feat[gi] = sample_q[gi*FW +: FW];
    end
  endgenerate

  // Term datapath: term k walks the features from the top index down.
  logic [CNT_W-1:0]        feat_idx;
  logic signed [FW-1:0]    feat_sel;
  logic signed [CW-1:0]    coeff_s;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] term_val;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] bias_eff;
  logic signed [ACC_W-1:0] acc_new;
  logic signed [ACC_W-1:0] node_sum;

  // Compute the current term, the running sum and the finished node sum.
  always_comb begin
    feat_idx = LAST_TERM - cnt_q;
    feat_sel = feat[feat_idx];
    coeff_s  = coeff;
    prod     = feat_sel * coeff_s;
    if (is_one) term_val = {{(ACC_W-FW){feat_sel[FW-1]}}, feat_sel};
    else        term_val = {{(ACC_W-PW){prod[PW-1]}}, prod};
    bias_ext = {{(ACC_W-BW){bias[BW-1]}}, bias};
    // With a single-term node the bias has not been latched yet.
    bias_eff = (cnt_q == '0) ? bias_ext : bias_q;
    acc_new  = acc_q + term_val;
    node_sum = acc_new + bias_eff;
  end

  // Next-state logic: sample capture, term accumulation and node decision.
  // The decision is registered on the edge that accepts the last term, so
  // the DECIDE cycle is the cycle in which dir_valid is high.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    acc_d    = acc_q;
    bias_d   = bias_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    dir_d    = dir_q;
    dvalid_d = 1'b0;
    result_d = result_q;
    perr_d   = perr_q;
    case (state_q)
      IDLE: begin
        if (term_valid) perr_d = 1'b1;
        if (sample_valid) begin
          sample_d = sample;
          acc_d    = '0;
          cnt_d    = '0;
          ready_d  = 1'b0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (path_done) begin
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (term_valid) begin
          if (cnt_q == '0) bias_d = bias_ext;
          if (cnt_q == LAST_TERM) begin
            result_d = node_sum;
            dir_d    = ~node_sum[ACC_W-1];
            dvalid_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = DECIDE;
          end else begin
            acc_d = acc_new;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DECIDE: begin
        // The decision pulse is already on the outputs; path_done here only
        // ends the walk.
        if (term_valid) perr_d = 1'b1;
        if (path_done) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= '0;
      acc_q    <= '0;
      bias_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      dir_q    <= 1'b0;
      dvalid_q <= 1'b0;
      result_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      bias_q   <= bias_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      dir_q    <= dir_d;
      dvalid_q <= dvalid_d;
      result_q <= result_d;
      perr_q   <= perr_d;
    end
  end

  assign sample_ready    = ready_q;
  assign child_direction = dir_q;
  assign dir_valid       = dvalid_q;
  assign result          = result_q;
  assign protocol_error  = perr_q;

endmodule
